// File: rtl/mem_readback_pkg.sv
// Shared types and constants for the mem_readback streaming BRAM readback engine.
package mem_readback_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } rb_state_t;

  localparam int CSUM_W        = 32;
  localparam int RB_FIFO_DEPTH = 2;

endpackage

// File: rtl/mem_readback_skid_fifo.sv
// rb_skid_fifo: small valid/ready FIFO holding landed RAM words, with an occupancy output.
module rb_skid_fifo
  import mem_readback_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     push_valid_i,
  input  logic [W-1:0]                             push_data_i,
  output logic                                     pop_valid_o,
  output logic [W-1:0]                             pop_data_o,
  input  logic                                     pop_ready_i,
  output logic [$clog2(RB_FIFO_DEPTH+1)-1:0]       occupancy_o
);

  localparam int PTR_W = $clog2(RB_FIFO_DEPTH);
  localparam int OCC_W = $clog2(RB_FIFO_DEPTH + 1);

  logic [W-1:0]     mem_q [RB_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] count_q;
  logic             push, pop;

  assign push = push_valid_i && (count_q != OCC_W'(RB_FIFO_DEPTH));
  assign pop  = pop_ready_i && (count_q != '0);

  // Storage is cleared on reset so the output word reads zero after a flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < RB_FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + OCC_W'(push) - OCC_W'(pop);
    end
  end

  assign pop_valid_o = (count_q != '0);
  assign pop_data_o  = mem_q[rd_ptr_q];
  assign occupancy_o = count_q;

endmodule

// File: rtl/mem_readback.sv
// Sweeps an address window through a registered-output BRAM and streams the words out.
// Optional running checksum is built only when MEM_READBACK_CHECKSUM_EN is defined.
module mem_readback
  import mem_readback_pkg::*;
#(
  parameter int WID_MEM   = 16,
  parameter int DEPTH_MEM = 4096,
  parameter int ADDR_W    = $clog2(DEPTH_MEM)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   cfg_base,
  input  logic [ADDR_W:0]     cfg_len,
  output logic [ADDR_W-1:0]   raddr,
  input  logic [WID_MEM-1:0]  rdata,
  output logic [WID_MEM-1:0]  m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last,
  output logic                busy,
  output logic                done,
  output logic [CSUM_W-1:0]   checksum
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int OCC_W = $clog2(RB_FIFO_DEPTH + 1);

  rb_state_t         state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, raddr_q, raddr_d;
  logic [CNT_W-1:0]  len_q, len_d, issued_q, issued_d, emitted_q, emitted_d;
  logic              prime_q, prime_d, inflight_q, done_q, done_d;
  logic              issue, pop, fifo_valid;
  logic [WID_MEM-1:0] fifo_data;
  logic [OCC_W-1:0]  occ;
  logic [2:0]        credit;

  // The RAM samples raddr every edge; advancing raddr is what issues a read,
  // and the word it returns is pushed one edge later while inflight is set.
  rb_skid_fifo #(.W(WID_MEM)) u_buf (
    .clk          (clk),
    .reset        (reset),
    .push_valid_i (inflight_q),
    .push_data_i  (rdata),
    .pop_valid_o  (fifo_valid),
    .pop_data_o   (fifo_data),
    .pop_ready_i  (m_ready),
    .occupancy_o  (occ)
  );

  assign pop    = fifo_valid & m_ready;
  assign credit = 3'(occ) + 3'(inflight_q) - 3'(pop);

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    raddr_d   = raddr_q;
    issued_d  = issued_q;
    emitted_d = pop ? emitted_q + 1'b1 : emitted_q;
    prime_d   = prime_q;
    issue     = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d    = cfg_base;
          len_d     = cfg_len;
          issued_d  = '0;
          emitted_d = '0;
          prime_d   = 1'b1;
          state_d   = (cfg_len == '0) ? FINISH : SCAN;
        end
      end
      SCAN: begin
        // First SCAN cycle only loads the base address so the RAM sees it next edge.
        if (prime_q) begin
          raddr_d = base_q;
          prime_d = 1'b0;
        end else if (credit < 3'd2) begin
          issue    = 1'b1;
          raddr_d  = raddr_q + 1'b1;
          issued_d = issued_q + 1'b1;
          if (issued_d == len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (credit == 3'd0) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end
      end
      FINISH: begin
        // An empty sweep reports completion as FINISH is left.
        state_d = IDLE;
        done_d  = (len_q == '0);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      raddr_q    <= '0;
      issued_q   <= '0;
      emitted_q  <= '0;
      prime_q    <= 1'b0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      raddr_q    <= raddr_d;
      issued_q   <= issued_d;
      emitted_q  <= emitted_d;
      prime_q    <= prime_d;
      inflight_q <= issue;
      done_q     <= done_d;
    end
  end

  assign raddr   = raddr_q;
  assign m_valid = fifo_valid;
  assign m_data  = fifo_data;
  assign m_last  = fifo_valid && ((emitted_q + 1'b1) == len_q);
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

`ifdef MEM_READBACK_CHECKSUM_EN
  logic [CSUM_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (state_q == IDLE && start) csum_d = '0;
    else if (pop) csum_d = csum_q + CSUM_W'(fifo_data);
  end

  always_ff @(posedge clk) begin
    if (reset) csum_q <= '0;
    else       csum_q <= csum_d;
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: doc/mem_readback.md
# mem_readback

Streaming readback engine placed directly downstream of the block-RAM `memory` instance. It sweeps a programmable address window through the RAM read port and absorbs the RAM's one-cycle registered read latency. It emits each word on a valid/ready stream with backpressure, so the contents of reinitialised BRAM can be dumped or checked after a bitstream reload.

## Interface
- `WID_MEM`, default 16: data width; matches the RAM word width.
- `DEPTH_MEM`, default 4096: RAM depth in words; a power of two.
- `ADDR_W`, default 12: `$clog2(DEPTH_MEM)`; width of `raddr`.
- `clk`, in, 1: single clock; all logic on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: one-cycle request to begin a sweep; sampled only in IDLE.
- `cfg_base`, in, ADDR_W: first address of the sweep; sampled with `start`.
- `cfg_len`, in, ADDR_W+1: number of words, 0..DEPTH_MEM; sampled with `start`.
- `raddr`, out, ADDR_W: registered read address driven to the RAM.
- `rdata`, in, WID_MEM: the RAM `dout`, valid one edge after `raddr` is sampled.
- `m_data`, out, WID_MEM: output word.
- `m_valid`, out, 1: `m_data` is valid.
- `m_ready`, in, 1: downstream accepts the word.
- `m_last`, out, 1: high with the final word of the sweep.
- `busy`, out, 1: high from `start` acceptance until the `done` pulse.
- `done`, out, 1: one-cycle pulse when the sweep completes.
- `checksum`, out, 32: running checksum (see Configuration).

## Operation
- States:
  - IDLE: `busy`=0. `start`=1 latches base/len and clears the checksum.
    - len≠0: go to SCAN.
    - len=0: go to FINISH.
  - SCAN: issue reads while issue credit exists. Go to DRAIN when all len reads are issued.
  - DRAIN: wait until the in-flight read has landed and the buffer has emptied. Then go to FINISH.
  - FINISH: `done`=1 for this cycle only, then go to IDLE.
- Issue credit: a read is issued this cycle iff (occupancy − pop_this_cycle + inflight) < 2. inflight is a 1-bit flag set by an issue and cleared when the word lands.
- Address arithmetic: `raddr` increments modulo DEPTH_MEM, so it wraps from DEPTH_MEM−1 to 0.
- Counters: issued-read and emitted-beat counters are ADDR_W+1 bits wide.
- Output buffer: a 2-entry FIFO. A landing `rdata` word is always written into it; credit guarantees there is room.
- Stream rules:
  - `m_data` and `m_last` are held stable while `m_valid`=1 and `m_ready`=0.
  - `m_valid` never drops without a handshake.
- `m_last`: asserted on the beat whose emitted count equals len.
- `start` while `busy`: ignored; no state change.
- Reset mid-operation: go to IDLE. The buffer is flushed, the in-flight read is discarded, and no `done` pulse is produced.
- Reset values: `raddr`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0, `done`=0, `checksum`=0.

## Timing
- Pipeline for `start` accepted at edge k:
  - `raddr`=cfg_base after edge k+1.
  - RAM `dout` valid after edge k+2.
  - Word written into the buffer at edge k+3.
  - First `m_valid` after edge k+3.
- With `m_ready` held at 1, throughput is one beat per cycle, with no bubbles after the first beat.
- `done` is high in the cycle after the `m_last` handshake edge.
- For len=0, `done` is high after edge k+1, with no beats.

## Configuration
- `MEM_READBACK_CHECKSUM_EN` defined:
  - `checksum` is a 32-bit modular sum of zero-extended `m_data`, updated on each handshake.
  - Cleared on `start` acceptance.
  - Holds its value after `done` until the next `start`.
- `MEM_READBACK_CHECKSUM_EN` undefined: no accumulator logic is built and `checksum` is tied to 0.

## Structure
- Package `mem_readback_pkg` holds:
  - the state enum `rb_state_t` (IDLE, SCAN, DRAIN, FINISH);
  - `CSUM_W`=32;
  - `RB_FIFO_DEPTH`=2.
- Sub-module `rb_skid_fifo`: a 2-entry valid/ready FIFO with an occupancy output. It is used for the output buffer.

## Test plan
- RAM preloaded with words equal to their address; base=0, len=4, `m_ready`=1:
  - beats 0,1,2,3 back-to-back, first `m_valid` after edge k+3;
  - `m_last` on beat 3;
  - `done` in the next cycle;
  - `checksum`=0x6 with the macro, 0 without.
- Same load; base=8, len=6, `m_ready` toggling 1,0,1,0…:
  - beats 8..13 in order, with no drop and no duplicate;
  - `m_data` stable across every stalled cycle.
- Wrap test, base=4094, len=4:
  - `raddr` sequence 4094, 4095, 0, 1;
  - beats 4094, 4095, 0, 1.
- len=0 → `busy` for one cycle, `done` after edge k+1, `m_valid` never asserted.
- Reset mid-sweep: `reset` high for 1 cycle after 2 beats of a len=16 sweep.
  - All outputs return to reset values and there is no `done`.
  - A new `start` with base=0, len=2 yields beats 0, 1.
- `start` pulsed again mid-sweep with a different base → ignored; the original sequence completes unchanged.
